// File: rtl/keccak_ctrl.sv
// Keccak sponge controller: sequences absorb, 24 permutation rounds and squeeze.
// Optional internal round-constant LFSR is enabled by defining KECCAK_CTRL_RC_LFSR_EN.
module keccak_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  input  logic [4:0]  round_num,
  output logic        en_counter,
  output logic        state_clr,
  output logic        absorb_en,
  output logic        round_en,
  output logic [63:0] rc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PERMUTE  = 2'd1;
  localparam logic [1:0] S_WAIT_BLK = 2'd2;
  localparam logic [1:0] S_SQUEEZE  = 2'd3;

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;
  logic       accept;

  always_comb begin
    in_ready   = (state_q == S_IDLE) || (state_q == S_WAIT_BLK);
    accept     = in_ready && in_valid;
    absorb_en  = accept;
    state_clr  = accept && (state_q == S_IDLE);
    round_en   = (state_q == S_PERMUTE);
    en_counter = (state_q == S_PERMUTE);
    out_valid  = (state_q == S_SQUEEZE);
    busy       = (state_q != S_IDLE);
  end

  // Any round index of 24 or more in PERMUTE means the counter ran away; abandon the message.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE, S_WAIT_BLK: begin
        if (accept) begin
          state_d = S_PERMUTE;
          last_d  = in_last;
        end
      end
      S_PERMUTE: begin
        if (round_num >= 5'd24) begin
          state_d = S_IDLE;
        end else if (round_num == 5'd23) begin
          state_d = last_q ? S_SQUEEZE : S_WAIT_BLK;
        end
      end
      S_SQUEEZE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

`ifdef KECCAK_CTRL_RC_LFSR_EN
  logic [7:0]  lfsr_q, lfsr_d;
  logic [7:0]  lfsr_walk;
  logic [63:0] rc_round;

  // Seven LFSR steps per round; step j's output bit lands at rc bit 2^j-1.
  always_comb begin
    lfsr_walk = lfsr_q;
    rc_round  = '0;
    for (int j = 0; j < 7; j++) begin
      rc_round[6'((1 << j) - 1)] = lfsr_walk[0];
      lfsr_walk = {lfsr_walk[6:0], 1'b0} ^ (lfsr_walk[7] ? 8'h71 : 8'h00);
    end
  end

  always_comb begin
    lfsr_d = lfsr_q;
    if (accept) begin
      lfsr_d = 8'h01;
    end else if (state_q == S_PERMUTE) begin
      lfsr_d = lfsr_walk;
    end
    rc = (state_q == S_PERMUTE) ? rc_round : 64'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 8'h01;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign rc = 64'h0;
`endif

endmodule
